// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and constants for the data RAM arbiter slice.
package data_ram_arbiter_pkg;

  localparam int RAMAddrBus = 32;
  localparam int RAMDataBus = 32;

  localparam logic [RAMDataBus-1:0] ZeroWord    = '0;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic                  ResetEnable = 1'b1;

  // Cycles r1 may lose to r0 before it is forced to win.
  localparam int ArbStarveLimit = 4;

  typedef enum logic {
    ArbIdle  = 1'b0,
    ArbMerge = 1'b1
  } arb_state_t;

  // The RAM is word-addressed in practice; byte offset bits are dropped.
  function automatic logic [RAMAddrBus-1:0] word_addr(input logic [RAMAddrBus-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_ram_byte_merge.sv
// Combinational byte-lane merge: selects each byte from the new word when its
// enable is set, otherwise keeps the old byte.
module ram_byte_merge
  import data_ram_arbiter_pkg::*;
(
  input  logic [RAMDataBus-1:0] i_old,
  input  logic [RAMDataBus-1:0] i_new,
  input  logic [3:0]            i_be,
  output logic [RAMDataBus-1:0] o_merged
);

  // Per-lane select between stored and incoming byte.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    o_merged = i_old;
    for (int k = 0; k < 4; k++) begin
      if (i_be[k]) o_merged[8*k +: 8] = i_new[8*k +: 8];
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-requester arbiter and access sequencer in front of the data RAM.
// r0 has fixed priority; r1 is forced through after STARVE_LIMIT lost cycles.
// Sub-word stores are done as read (grant cycle) then write (MERGE cycle).
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = ArbStarveLimit
) (
  input  logic                  i_Clk,
  input  logic                  i_reset,

  input  logic                  i_r0_req,
  input  logic                  i_r0_we,
  input  logic [3:0]            i_r0_be,
  input  logic [RAMAddrBus-1:0] i_r0_addr,
  input  logic [RAMDataBus-1:0] i_r0_wdata,
  output logic                  o_r0_gnt,
  output logic                  o_r0_rvalid,
  output logic [RAMDataBus-1:0] o_r0_rdata,

  input  logic                  i_r1_req,
  input  logic                  i_r1_we,
  input  logic [3:0]            i_r1_be,
  input  logic [RAMAddrBus-1:0] i_r1_addr,
  input  logic [RAMDataBus-1:0] i_r1_wdata,
  output logic                  o_r1_gnt,
  output logic                  o_r1_rvalid,
  output logic [RAMDataBus-1:0] o_r1_rdata,

  output logic                  o_ram_we,
  output logic [RAMAddrBus-1:0] o_ram_w_addr,
  output logic [RAMDataBus-1:0] o_ram_w_data,
  output logic [RAMAddrBus-1:0] o_ram_r_addr,
  input  logic [RAMDataBus-1:0] i_ram_r_data
);

  localparam int CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_t            r_state;
  logic [CntW-1:0]       r_starve_cnt;
  logic [RAMAddrBus-1:0] r_mrg_addr;
  logic [RAMDataBus-1:0] r_mrg_data;
  logic                  r_mrg_owner;
  logic                  r_r0_rvalid;
  logic [RAMDataBus-1:0] r_r0_rdata;
  logic                  r_r1_rvalid;
  logic [RAMDataBus-1:0] r_r1_rdata;

  logic                  w_idle;
  logic                  w_starved;
  logic                  w_r1_wins;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_any_gnt;
  logic                  w_sel_we;
  logic [3:0]            w_sel_be;
  logic [RAMAddrBus-1:0] w_sel_addr;
  logic [RAMDataBus-1:0] w_sel_wdata;
  logic                  w_full;
  logic                  w_partial;
  logic [RAMDataBus-1:0] w_merged;

  // Arbitration and selection of the winning request.
  always_comb begin
    // NOTE: reset gates the combinational outputs too, so a MERGE interrupted by reset never writes.
    w_idle      = (r_state == ArbIdle) && !i_reset;
    w_starved   = (r_starve_cnt == CntW'(STARVE_LIMIT));
    w_r1_wins   = i_r1_req && (!i_r0_req || w_starved);
    w_gnt0      = w_idle && i_r0_req && !w_r1_wins;
    w_gnt1      = w_idle && w_r1_wins;
    w_any_gnt   = w_gnt0 || w_gnt1;
    w_sel_we    = w_gnt1 ? i_r1_we    : i_r0_we;
    w_sel_be    = w_gnt1 ? i_r1_be    : i_r0_be;
    w_sel_addr  = w_gnt1 ? i_r1_addr  : i_r0_addr;
    w_sel_wdata = w_gnt1 ? i_r1_wdata : i_r0_wdata;
    w_full      = (w_sel_be == 4'hF);
    w_partial   = (w_sel_be != 4'hF) && (w_sel_be != 4'h0);
  end

  ram_byte_merge u_merge (
    .i_old    (i_ram_r_data),
    .i_new    (w_sel_wdata),
    .i_be     (w_sel_be),
    .o_merged (w_merged)
  );

  // RAM port drive; every bus is zero when the port is unused.
  always_comb begin
    o_ram_we     = 1'b0;
    o_ram_w_addr = '0;
    o_ram_w_data = ZeroWord;
    o_ram_r_addr = '0;
    if (!i_reset) begin
      if (r_state == ArbMerge) begin
        o_ram_we     = WriteEnable;
        o_ram_w_addr = r_mrg_addr;
        o_ram_w_data = r_mrg_data;
      end else if (w_any_gnt) begin
        if (!w_sel_we || w_partial) begin
          o_ram_r_addr = word_addr(w_sel_addr);
        end else if (w_full) begin
          o_ram_we     = WriteEnable;
          o_ram_w_addr = word_addr(w_sel_addr);
          o_ram_w_data = w_sel_wdata;
        end
      end
    end
  end

  // FSM, starvation counter and registered responses.
  always_ff @(posedge i_Clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (i_reset == ResetEnable) begin
      r_state      <= ArbIdle;
      r_starve_cnt <= '0;
      r_mrg_addr   <= '0;
      r_mrg_data   <= ZeroWord;
      r_mrg_owner  <= 1'b0;
      r_r0_rvalid  <= 1'b0;
      r_r0_rdata   <= ZeroWord;
      r_r1_rvalid  <= 1'b0;
      r_r1_rdata   <= ZeroWord;
    end else begin
      r_r0_rvalid <= 1'b0;
      r_r0_rdata  <= ZeroWord;
      r_r1_rvalid <= 1'b0;
      r_r1_rdata  <= ZeroWord;

      if (!i_r1_req || w_gnt1) r_starve_cnt <= '0;
      else if (!w_starved)     r_starve_cnt <= r_starve_cnt + 1'b1;

      case (r_state)
        ArbIdle: begin
          if (w_any_gnt) begin
            if (w_sel_we && w_partial) begin
              r_mrg_addr  <= word_addr(w_sel_addr);
              r_mrg_data  <= w_merged;
              r_mrg_owner <= w_gnt1;
              r_state     <= ArbMerge;
            end else if (w_gnt1) begin
              r_r1_rvalid <= 1'b1;
              r_r1_rdata  <= w_sel_we ? ZeroWord : i_ram_r_data;
            end else begin
              r_r0_rvalid <= 1'b1;
              r_r0_rdata  <= w_sel_we ? ZeroWord : i_ram_r_data;
            end
          end
        end
        ArbMerge: begin
          r_state <= ArbIdle;
          if (r_mrg_owner) r_r1_rvalid <= 1'b1;
          else             r_r0_rvalid <= 1'b1;
        end
        default: r_state <= ArbIdle;
      endcase
    end
  end

  assign o_r0_gnt    = w_gnt0;
  assign o_r1_gnt    = w_gnt1;
  assign o_r0_rvalid = r_r0_rvalid;
  assign o_r0_rdata  = r_r0_rdata;
  assign o_r1_rvalid = r_r1_rvalid;
  assign o_r1_rdata  = r_r1_rdata;

endmodule
